mem_port_arbiter: RTL and testbench

//  Shares one single-ported instruction/data memory between the IF-stage fetch requester (read-only)
//  and the MEM-stage load/store requester (driven by MEM_READ2/MEM_WRITE from decode).
//  One access is in flight at a time; GNT/VALID handshakes tell the pipeline when to stall.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_valid;
  logic [31:0]       d_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_be;
  logic [31:0]       m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           m_en, m_we, m_addr, m_wdata, m_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           m_en, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data load/store.
// Data wins by default; a consecutive-data-grant limit guarantees fetch progress.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int RD_LAT       = 2,
  parameter int MAX_D_STREAK = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] CNT_LOAD   = 3'(RD_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        streak_q;
  logic              owner_d_q;
  logic              grant_if, grant_d, capture;
  logic              if_valid_q, d_valid_q;
  logic [31:0]       if_rdata_q, d_rdata_q;
  logic [ADDR_W-1:0] m_addr_q, m_addr_nx;
  logic [31:0]       m_wdata_q, m_wdata_nx;
  logic [3:0]        m_be_q, m_be_nx;

  // Grants only happen in IDLE; stores complete without a WAIT phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    capture  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.d_req && !(bus.if_req && streak_q == STREAK_MAX)) begin
            grant_d = 1'b1;
            if (!bus.d_we) begin
              state_d = WAIT;
              cnt_d   = CNT_LOAD;
            end
          end else if (bus.if_req) begin
            grant_if = 1'b1;
            state_d  = WAIT;
            cnt_d    = CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            capture = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    m_addr_nx  = m_addr_q;
    m_wdata_nx = m_wdata_q;
    m_be_nx    = m_be_q;
    if (grant_d) begin
      m_addr_nx  = bus.d_addr;
      m_wdata_nx = bus.d_wdata;
      m_be_nx    = bus.d_be;
    end else if (grant_if) begin
      m_addr_nx = bus.if_addr;
      m_be_nx   = 4'b1111;
    end
  end

  assign bus.if_gnt   = grant_if;
  assign bus.d_gnt    = grant_d;
  assign bus.m_en     = grant_if | grant_d;
  assign bus.m_we     = grant_d & bus.d_we;
  assign bus.m_addr   = m_addr_nx;
  assign bus.m_wdata  = m_wdata_nx;
  assign bus.m_be     = m_be_nx;
  assign bus.if_valid = if_valid_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      streak_q   <= 4'd0;
      owner_d_q  <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
      m_addr_q   <= '0;
      m_wdata_q  <= 32'd0;
      m_be_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_addr_q   <= m_addr_nx;
      m_wdata_q  <= m_wdata_nx;
      m_be_q     <= m_be_nx;
      if_valid_q <= capture & ~owner_d_q;
      d_valid_q  <= (grant_d & bus.d_we) | (capture & owner_d_q);
      if (grant_d || grant_if) begin
        owner_d_q <= grant_d;
      end
      if (capture && owner_d_q) begin
        d_rdata_q <= bus.m_rdata;
      end
      if (capture && !owner_d_q) begin
        if_rdata_q <= bus.m_rdata;
      end
      // A waiting fetch is what makes a data win count toward the limit.
      if (state_q == IDLE) begin
        if (grant_d && bus.if_req) begin
          streak_q <= (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
        end else if (grant_if || !bus.if_req) begin
          streak_q <= 4'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=2/MAX=4 and RD_LAT=1/MAX=2) share stimulus,
// a timeline model checks every cycle, and directed literals pin the model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        drv_if_req, drv_d_req, drv_d_we;
  logic [31:0] drv_if_addr, drv_d_addr, drv_d_wdata, drv_m_rdata;
  logic [3:0]  drv_d_be;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(32)) bus1 ();

  assign bus0.if_req  = drv_if_req;
  assign bus0.if_addr = drv_if_addr;
  assign bus0.d_req   = drv_d_req;
  assign bus0.d_we    = drv_d_we;
  assign bus0.d_addr  = drv_d_addr;
  assign bus0.d_wdata = drv_d_wdata;
  assign bus0.d_be    = drv_d_be;
  assign bus0.m_rdata = drv_m_rdata;
  assign bus1.if_req  = drv_if_req;
  assign bus1.if_addr = drv_if_addr;
  assign bus1.d_req   = drv_d_req;
  assign bus1.d_we    = drv_d_we;
  assign bus1.d_addr  = drv_d_addr;
  assign bus1.d_wdata = drv_d_wdata;
  assign bus1.d_be    = drv_d_be;
  assign bus1.m_rdata = drv_m_rdata;

  mem_port_arbiter #(.ADDR_W(32), .RD_LAT(2), .MAX_D_STREAK(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  mem_port_arbiter #(.ADDR_W(32), .RD_LAT(1), .MAX_D_STREAK(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  typedef struct packed {
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
  } outs_t;

  outs_t act [2];
  assign act[0] = {bus0.if_gnt, bus0.if_valid, bus0.if_rdata, bus0.d_gnt, bus0.d_valid,
                   bus0.d_rdata, bus0.m_en, bus0.m_we, bus0.m_addr, bus0.m_wdata, bus0.m_be};
  assign act[1] = {bus1.if_gnt, bus1.if_valid, bus1.if_rdata, bus1.d_gnt, bus1.d_valid,
                   bus1.d_rdata, bus1.m_en, bus1.m_we, bus1.m_addr, bus1.m_wdata, bus1.m_be};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, inst, cyc, actual, expected);
    end
  endtask

  // Timeline model: an access granted at cycle t occupies the port until a known cycle,
  // reads sample memory data at t+lat and report it at t+lat+1, stores report at t+1.
  int          lat [2];
  int          maxs [2];
  int          busy_until [2];
  int          sample_cyc [2];
  int          valid_cyc [2];
  int          streak [2];
  bit          owner_d [2];
  logic [31:0] mdl_if_rdata [2];
  logic [31:0] mdl_d_rdata [2];
  logic [31:0] mdl_addr [2];
  logic [31:0] mdl_wdata [2];
  logic [3:0]  mdl_be [2];

  task automatic modelReset(input int k);
    busy_until[k]   = cyc + 1;
    sample_cyc[k]   = -1;
    valid_cyc[k]    = -1;
    streak[k]       = 0;
    owner_d[k]      = 1'b0;
    mdl_if_rdata[k] = 32'd0;
    mdl_d_rdata[k]  = 32'd0;
    mdl_addr[k]     = 32'd0;
    mdl_wdata[k]    = 32'd0;
    mdl_be[k]       = 4'd0;
  endtask

  task automatic modelStep(input int k);
    bit          free, win_d, win_if, is_store;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    free     = (cyc >= busy_until[k]);
    win_d    = free && drv_d_req && !(drv_if_req && streak[k] == maxs[k]);
    win_if   = free && !win_d && drv_if_req;
    is_store = win_d && drv_d_we;
    e_addr   = win_d ? drv_d_addr : (win_if ? drv_if_addr : mdl_addr[k]);
    e_be     = win_d ? drv_d_be : (win_if ? 4'b1111 : mdl_be[k]);

    checkOutput("if_gnt", k, 32'(act[k].if_gnt), 32'(win_if));
    checkOutput("d_gnt", k, 32'(act[k].d_gnt), 32'(win_d));
    checkOutput("m_en", k, 32'(act[k].m_en), 32'(win_d || win_if));
    checkOutput("m_we", k, 32'(act[k].m_we), 32'(is_store));
    checkOutput("m_addr", k, act[k].m_addr, e_addr);
    checkOutput("m_be", k, 32'(act[k].m_be), 32'(e_be));
    if (is_store) checkOutput("m_wdata", k, act[k].m_wdata, drv_d_wdata);
    checkOutput("if_valid", k, 32'(act[k].if_valid), 32'(valid_cyc[k] == cyc && !owner_d[k]));
    checkOutput("d_valid", k, 32'(act[k].d_valid), 32'(valid_cyc[k] == cyc && owner_d[k]));
    checkOutput("if_rdata", k, act[k].if_rdata, mdl_if_rdata[k]);
    checkOutput("d_rdata", k, act[k].d_rdata, mdl_d_rdata[k]);

    if (sample_cyc[k] == cyc) begin
      if (owner_d[k]) mdl_d_rdata[k] = drv_m_rdata;
      else            mdl_if_rdata[k] = drv_m_rdata;
    end
    if (win_d || win_if) begin
      owner_d[k]  = win_d;
      mdl_addr[k] = e_addr;
      mdl_be[k]   = e_be;
      if (win_d) mdl_wdata[k] = drv_d_wdata;
      if (is_store) begin
        sample_cyc[k] = -1;
        valid_cyc[k]  = cyc + 1;
        busy_until[k] = cyc + 1;
      end else begin
        sample_cyc[k] = cyc + lat[k];
        valid_cyc[k]  = cyc + lat[k] + 1;
        busy_until[k] = cyc + lat[k] + 1;
      end
    end
    if (free) begin
      if (win_d && drv_if_req) streak[k] = streak[k] + 1;
      else if (win_if || !drv_if_req) streak[k] = 0;
    end
  endtask

  initial begin
    lat[0]  = 2;
    lat[1]  = 1;
    maxs[0] = 4;
    maxs[1] = 2;
    for (int k = 0; k < 2; k++) modelReset(k);
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (rst) modelReset(k);
        else     modelStep(k);
      end
      cyc++;
    end
  end

  task automatic applyStimulus(input logic r, input logic ifr, input logic [31:0] ifa,
                               input logic dr, input logic dwe, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] dbe,
                               input logic [31:0] mrd);
    @(negedge clk);
    rst         = r;
    drv_if_req  = ifr;
    drv_if_addr = ifa;
    drv_d_req   = dr;
    drv_d_we    = dwe;
    drv_d_addr  = da;
    drv_d_wdata = dwd;
    drv_d_be    = dbe;
    drv_m_rdata = mrd;
    #2;
  endtask

  task automatic fetchOnly(input logic ifr, input logic [31:0] ifa, input logic [31:0] mrd);
    applyStimulus(1'b0, ifr, ifa, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, mrd);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    drv_if_req  = 1'b0;
    drv_if_addr = 32'h0;
    drv_d_req   = 1'b0;
    drv_d_we    = 1'b0;
    drv_d_addr  = 32'h0;
    drv_d_wdata = 32'h0;
    drv_d_be    = 4'h0;
    drv_m_rdata = 32'h0;

    // Reset state
    resetCycle();
    fetchOnly(1'b0, 32'h0, 32'h0);
    checkOutput("rst_m_en", 0, 32'(act[0].m_en), 32'd0);
    checkOutput("rst_m_addr", 0, act[0].m_addr, 32'h0);
    checkOutput("rst_m_be", 0, 32'(act[0].m_be), 32'h0);
    checkOutput("rst_if_rdata", 0, act[0].if_rdata, 32'h0);

    // Single fetch with RD_LAT=2
    resetCycle();
    fetchOnly(1'b1, 32'h100, 32'h11111111);
    checkOutput("a_if_gnt", 0, 32'(act[0].if_gnt), 32'd1);
    checkOutput("a_m_addr", 0, act[0].m_addr, 32'h100);
    fetchOnly(1'b1, 32'h100, 32'h22222222);
    fetchOnly(1'b1, 32'h100, 32'hDEADBEEF);
    fetchOnly(1'b0, 32'h100, 32'h33333333);
    checkOutput("a_if_valid", 0, 32'(act[0].if_valid), 32'd1);
    checkOutput("a_if_rdata", 0, act[0].if_rdata, 32'hDEADBEEF);

    // Load beats pending fetch; fetch issues in the load's VALID cycle
    resetCycle();
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 32'h0);
    checkOutput("b_d_gnt", 0, 32'(act[0].d_gnt), 32'd1);
    checkOutput("b_if_gnt", 0, 32'(act[0].if_gnt), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 32'hCAFE0001);
    fetchOnly(1'b1, 32'h300, 32'h44444444);
    checkOutput("b_d_valid", 0, 32'(act[0].d_valid), 32'd1);
    checkOutput("b_d_rdata", 0, act[0].d_rdata, 32'hCAFE0001);
    checkOutput("b_if_gnt3", 0, 32'(act[0].if_gnt), 32'd1);
    checkOutput("b_m_addr3", 0, act[0].m_addr, 32'h300);
    fetchOnly(1'b1, 32'h300, 32'h55555555);
    fetchOnly(1'b1, 32'h300, 32'h0BADF00D);
    fetchOnly(1'b0, 32'h300, 32'h66666666);
    checkOutput("b_if_valid", 0, 32'(act[0].if_valid), 32'd1);
    checkOutput("b_if_rdata", 0, act[0].if_rdata, 32'h0BADF00D);

    // Store completes in one cycle; fetch withdrawn mid-access still completes
    resetCycle();
    applyStimulus(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011, 32'h0);
    checkOutput("c_m_we", 0, 32'(act[0].m_we), 32'd1);
    checkOutput("c_m_be", 0, 32'(act[0].m_be), 32'h3);
    checkOutput("c_m_wdata", 0, act[0].m_wdata, 32'h12345678);
    fetchOnly(1'b1, 32'h500, 32'h0);
    checkOutput("c_d_valid", 0, 32'(act[0].d_valid), 32'd1);
    checkOutput("c_if_gnt", 0, 32'(act[0].if_gnt), 32'd1);
    checkOutput("c_m_be1", 0, 32'(act[0].m_be), 32'hF);
    checkOutput("c_d_rdata", 0, act[0].d_rdata, 32'h0);
    fetchOnly(1'b1, 32'h500, 32'h0);
    fetchOnly(1'b0, 32'h500, 32'hA5A5A5A5);
    fetchOnly(1'b0, 32'h500, 32'h0);
    checkOutput("c_if_valid", 0, 32'(act[0].if_valid), 32'd1);
    checkOutput("c_if_rdata", 0, act[0].if_rdata, 32'hA5A5A5A5);

    // Data streak limit: D,D,D,D,IF then data again
    resetCycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h600, 1'b1, 1'b1, 32'h1000 + 32'(4 * i), 32'(i), 4'hF,
                    32'h50000000 + 32'(i));
      if (i < 4) checkOutput("d_streak_dgnt", 0, 32'(act[0].d_gnt), 32'd1);
      if (i == 4) checkOutput("d_streak_ifgnt", 0, 32'(act[0].if_gnt), 32'd1);
      if (i == 5) checkOutput("d_streak_wait", 0, 32'(act[0].m_en), 32'd0);
      if (i == 7) checkOutput("d_streak_dgnt7", 0, 32'(act[0].d_gnt), 32'd1);
    end

    // Reset during a read abandons it
    resetCycle();
    fetchOnly(1'b1, 32'h700, 32'h0);
    checkOutput("e_if_gnt0", 0, 32'(act[0].if_gnt), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    fetchOnly(1'b1, 32'h800, 32'h0);
    checkOutput("e_if_gnt2", 0, 32'(act[0].if_gnt), 32'd1);
    checkOutput("e_m_addr2", 0, act[0].m_addr, 32'h800);
    checkOutput("e_if_valid2", 0, 32'(act[0].if_valid), 32'd0);
    fetchOnly(1'b0, 32'h800, 32'h0);
    checkOutput("e_if_valid3", 0, 32'(act[0].if_valid), 32'd0);
    fetchOnly(1'b0, 32'h800, 32'h77777777);
    fetchOnly(1'b0, 32'h800, 32'h0);
    checkOutput("e_if_valid5", 0, 32'(act[0].if_valid), 32'd1);
    checkOutput("e_if_rdata5", 0, act[0].if_rdata, 32'h77777777);

    // Back-to-back fetches on the RD_LAT=1 instance
    resetCycle();
    for (int i = 0; i < 8; i++) begin
      fetchOnly(i < 7, 32'h900, 32'hF0000000 + 32'(i));
      if (i % 2 == 0 && i < 6) checkOutput("f_if_gnt", 1, 32'(act[1].if_gnt), 32'd1);
      if (i % 2 == 1 && i < 5) checkOutput("f_if_gnt_off", 1, 32'(act[1].if_gnt), 32'd0);
      if (i % 2 == 0 && i > 0 && i < 7) checkOutput("f_if_valid", 1, 32'(act[1].if_valid), 32'd1);
      if (i == 6) checkOutput("f_if_rdata", 1, act[1].if_rdata, 32'hF0000005);
    end

    fetchOnly(1'b0, 32'h0, 32'h0);
    fetchOnly(1'b0, 32'h0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
